// File: rtl/anneal_ctrl_pkg.sv
// Shared definitions for the annealing run controller: one-hot state encoding,
// KEY indices and the saturating sweep-total increment.
package anneal_ctrl_pkg;

    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_REQ      = 6'b000010,
        ST_STEP     = 6'b000100,
        ST_PAUSED   = 6'b001000,
        ST_ABORTING = 6'b010000,
        ST_DONE     = 6'b100000
    } state_t;

    localparam int KEY_START = 0;
    localparam int KEY_PAUSE = 1;
    localparam int KEY_ABORT = 2;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises one active-low pushbutton, debounces it and emits a one-cycle
// pulse when the debounced level turns pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic key_n_raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;
    logic          w_pressed;

    assign w_pressed = ~r_sync2;

    // Synchroniser, stability counter and press-edge detector.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= key_n_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            if (w_pressed != r_level) begin
                if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= w_pressed;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/anneal_run_ctrl.sv
// Sequences one annealing run: KEY commands, sweep req/ack handshake,
// temperature-index stepping and LED/HEX status publishing.
module anneal_run_ctrl
    import anneal_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SWEEPS_PER_STEP = 16,
    parameter int NUM_STEPS       = 64,
    parameter int IDX_W           = 6
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [3:0]       keys_export,
    output logic             sweep_req,
    input  logic             sweep_ack,
    output logic [IDX_W-1:0] temp_idx,
    output logic             busy,
    output logic             done,
    output logic [9:0]       leds_export,
    output logic [31:0]      hex30_export
);
    localparam int CNT_W = $clog2(SWEEPS_PER_STEP + 1);

    logic [3:0]       w_level;
    logic [3:0]       w_press;
    logic             w_unused;
    logic             w_start;
    logic             w_pause;
    logic             w_abort;
    logic             w_ack;
    logic             w_cnt_full;
    logic             w_last;
    logic [IDX_W:0]   w_idx_step;
    state_t           w_state_nxt;

    state_t           r_state;
    logic [CNT_W-1:0] r_sweep_cnt;
    logic [IDX_W:0]   r_idx;
    logic [IDX_W-1:0] r_temp_idx;
    logic             r_pause_pend;
    logic             r_req;
    logic             r_busy;
    logic             r_done;
    logic [9:0]       r_leds;
    logic [31:0]      r_total;

    for (genvar g = 0; g < 4; g++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_clk      (clk_clk),
            .reset_reset_n(reset_reset_n),
            .key_n_raw    (keys_export[g]),
            .level        (w_level[g]),
            .press        (w_press[g])
        );
    end

    assign w_unused   = w_press[3];
    assign w_start    = w_press[KEY_START];
    assign w_pause    = w_press[KEY_PAUSE];
    assign w_abort    = w_press[KEY_ABORT];
    // An ack only means something while a request is outstanding.
    assign w_ack      = sweep_ack & r_req;
    assign w_cnt_full = (r_sweep_cnt == CNT_W'(SWEEPS_PER_STEP));
    assign w_idx_step = r_idx + (IDX_W + 1)'(w_cnt_full);
    assign w_last     = (w_idx_step == (IDX_W + 1)'(NUM_STEPS));

    // Next-state selection; abort outranks pause, which outranks start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start && !w_abort) w_state_nxt = ST_REQ;
                else                     w_state_nxt = r_state;
            end
            ST_REQ: begin
                if (w_abort)    w_state_nxt = w_ack ? ST_IDLE : ST_ABORTING;
                else if (w_ack) w_state_nxt = ST_STEP;
                else            w_state_nxt = ST_REQ;
            end
            ST_STEP: begin
                if (w_abort)                        w_state_nxt = ST_IDLE;
                else if (w_last)                    w_state_nxt = ST_DONE;
                else if (r_pause_pend || w_pause)   w_state_nxt = ST_PAUSED;
                else                                w_state_nxt = ST_REQ;
            end
            ST_PAUSED: begin
                if (w_abort)      w_state_nxt = ST_IDLE;
                else if (w_pause) w_state_nxt = ST_REQ;
                else              w_state_nxt = ST_PAUSED;
            end
            ST_ABORTING: begin
                if (w_ack) w_state_nxt = ST_IDLE;
                else       w_state_nxt = ST_ABORTING;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, counters and registered outputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state      <= ST_IDLE;
            r_sweep_cnt  <= '0;
            r_idx        <= '0;
            r_temp_idx   <= '0;
            r_pause_pend <= 1'b0;
            r_req        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_leds       <= 10'h001;
            r_total      <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= (w_state_nxt == ST_REQ) || (w_state_nxt == ST_ABORTING);
            r_busy  <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            r_leds  <= {w_level, 6'(w_state_nxt)};
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_state_nxt == ST_REQ) begin
                        r_sweep_cnt  <= '0;
                        r_idx        <= '0;
                        r_temp_idx   <= '0;
                        r_total      <= 32'd0;
                        r_done       <= 1'b0;
                        r_pause_pend <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (w_abort)      r_pause_pend <= 1'b0;
                    else if (w_pause) r_pause_pend <= 1'b1;
                    if (w_ack && !w_abort) begin
                        r_total     <= sat_inc32(r_total);
                        r_sweep_cnt <= r_sweep_cnt + CNT_W'(1);
                    end
                    if (w_ack && w_abort) begin
                        r_idx      <= '0;
                        r_temp_idx <= '0;
                    end
                end
                ST_STEP: begin
                    if (w_abort) begin
                        r_idx        <= '0;
                        r_temp_idx   <= '0;
                        r_pause_pend <= 1'b0;
                    end else begin
                        if (w_cnt_full) r_sweep_cnt <= '0;
                        r_idx <= w_idx_step;
                        if (w_last) begin
                            r_done     <= 1'b1;
                            r_temp_idx <= IDX_W'(NUM_STEPS - 1);
                        end else begin
                            r_temp_idx <= w_idx_step[IDX_W-1:0];
                        end
                        if (w_state_nxt == ST_PAUSED) r_pause_pend <= 1'b0;
                    end
                end
                ST_PAUSED, ST_ABORTING: begin
                    if (w_state_nxt == ST_IDLE) begin
                        r_idx      <= '0;
                        r_temp_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sweep_req    = r_req;
    assign temp_idx     = r_temp_idx;
    assign busy         = r_busy;
    assign done         = r_done;
    assign leds_export  = r_leds;
    assign hex30_export = r_total;

endmodule

// File: tb/tb_anneal_run_ctrl.sv
// Directed self-checking bench for anneal_run_ctrl with a short debounce and schedule.
module tb_anneal_run_ctrl;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       keys = 4'hF;
    logic             ack = 1'b0;
    logic             req;
    logic [IDX_W-1:0] tidx;
    logic             busy;
    logic             done;
    logic [9:0]       leds;
    logic [31:0]      hex;

    int total = 0;
    int bad   = 0;

    anneal_run_ctrl #(
        .DEBOUNCE_CYCLES(4), .SWEEPS_PER_STEP(2), .NUM_STEPS(3), .IDX_W(IDX_W)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .keys_export  (keys),
        .sweep_req    (req),
        .sweep_ack    (ack),
        .temp_idx     (tidx),
        .busy         (busy),
        .done         (done),
        .leds_export  (leds),
        .hex30_export (hex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req_seen"}, {31'd0, req}, 32'd1);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic do_sweep(input string tag, input int dly, input logic [IDX_W-1:0] exp_idx);
        wait_req(tag);
        check({tag, "_idx"}, 32'(tidx), 32'(exp_idx));
        repeat (dly) @(negedge clk);
        check({tag, "_req_held"}, {31'd0, req}, 32'd1);
        ack_pulse();
    endtask

    task automatic press_key(input int k);
        keys[k] = 1'b0;
        repeat (10) @(negedge clk);
        keys[k] = 1'b1;
    endtask

    initial begin
        int errs;
        int lat;
        logic [IDX_W-1:0] exp_idx [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};

        // Reset and idle hold
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tidx !== '0 ||
                hex !== 32'd0 || leds !== 10'h001) errs++;
        end
        check("idle_hold_cycles", 32'(errs), 32'd0);
        check("reset_leds", 32'(leds), 32'h001);
        check("reset_hex", hex, 32'd0);

        // Full run: start latency, then six handshakes
        keys[0] = 1'b0;
        lat = 0;
        while (req !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("start_latency", 32'(lat), 32'd8);
        check("led_key0_level", {31'd0, leds[6]}, 32'd1);
        check("busy_running", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        keys[0] = 1'b1;
        for (int i = 0; i < 6; i++) do_sweep($sformatf("run1_s%0d", i), 3, exp_idx[i]);
        repeat (3) @(negedge clk);
        check("run1_done", {31'd0, done}, 32'd1);
        check("run1_busy", {31'd0, busy}, 32'd0);
        check("run1_hex", hex, 32'd6);
        check("run1_led_done", {31'd0, leds[5]}, 32'd1);
        check("run1_idx_held", 32'(tidx), 32'd2);

        // Stray ack with no request is ignored
        ack_pulse();
        repeat (2) @(negedge clk);
        check("stray_ack_hex", hex, 32'd6);

        // Short glitch must not start a run
        keys[0] = 1'b0;
        repeat (3) @(negedge clk);
        keys[0] = 1'b1;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req !== 1'b0) errs++;
        end
        check("glitch_no_req", 32'(errs), 32'd0);
        check("glitch_still_done", {31'd0, done}, 32'd1);

        // Pause while a request is pending
        press_key(0);
        wait_req("run2_s0");
        check("run2_hex_cleared", hex, 32'd0);
        check("run2_done_cleared", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        ack_pulse();
        wait_req("run2_s1");
        keys[1] = 1'b0;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) keys[1] = 1'b1;
            if (req !== 1'b1) errs++;
        end
        check("pause_req_held", 32'(errs), 32'd0);
        ack_pulse();
        repeat (2) @(negedge clk);
        check("paused_led", 32'(leds[5:0]), 32'h08);
        check("paused_busy", {31'd0, busy}, 32'd1);
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req !== 1'b0) errs++;
        end
        check("paused_no_req", 32'(errs), 32'd0);
        check("paused_hex", hex, 32'd2);
        press_key(1);
        for (int i = 2; i < 6; i++) do_sweep($sformatf("run2_s%0d", i), 3, exp_idx[i]);
        repeat (3) @(negedge clk);
        check("run2_done", {31'd0, done}, 32'd1);
        check("run2_hex", hex, 32'd6);

        // Abort mid-request: held to ack, ack not counted
        press_key(0);
        do_sweep("run3_s0", 3, 2'd0);
        do_sweep("run3_s1", 3, 2'd0);
        wait_req("run3_s2");
        check("run3_idx_before_abort", 32'(tidx), 32'd1);
        keys[2] = 1'b0;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req !== 1'b1) errs++;
        end
        check("abort_req_held", 32'(errs), 32'd0);
        check("aborting_led", 32'(leds[5:0]), 32'h10);
        ack_pulse();
        keys[2] = 1'b1;
        check("abort_idle_led", 32'(leds[5:0]), 32'h01);
        check("abort_req_low", {31'd0, req}, 32'd0);
        check("abort_idx", 32'(tidx), 32'd0);
        check("abort_hex", hex, 32'd2);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);

        // Pause and abort in the same cycle: abort wins
        press_key(0);
        wait_req("run4_s0");
        keys[2:1] = 2'b00;
        repeat (10) @(negedge clk);
        keys[2:1] = 2'b11;
        check("both_aborting_led", 32'(leds[5:0]), 32'h10);
        ack_pulse();
        check("both_idle_led", 32'(leds[5:0]), 32'h01);
        check("both_hex", hex, 32'd0);
        repeat (20) @(negedge clk);

        // Asynchronous reset in the middle of a handshake
        press_key(0);
        do_sweep("run5_s0", 3, 2'd0);
        wait_req("run5_s1");
        rst_n = 1'b0;
        #1;
        check("async_rst_req", {31'd0, req}, 32'd0);
        check("async_rst_leds", 32'(leds), 32'h001);
        check("async_rst_hex", hex, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_req", {31'd0, req}, 32'd0);
        check("post_rst_leds", 32'(leds[5:0]), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
